regfile_param: RTL and testbench
================================

# regfile_param

Parametrised register file for the pipelined MIPS datapath. It provides NUM_READ synchronous read ports and one write port. A same-cycle write is bypassed to any read port addressing the same register. Register 0 is optionally hardwired to zero. After reset, a hardware sweep clears every entry before the block reports ready, so no register contents are preloaded at elaboration time.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NUM_READ*ADDR_WIDTH  read addresses; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_READ*DATA_WIDTH  registered read data; port i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- wr_en  in  1  write enable
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- ready  out  1  1 = clear sweep finished; reads and writes are serviced
- wr_drop  out  1  one-cycle pulse: a write was presented while not ready and was discarded

## Operation
- FSM has two states: CLEAR and RUN. A clear pointer clr_ptr (ADDR_WIDTH bits) tracks the sweep.
- Reset, at any edge with reset=1 and in any state, including mid-sweep:
  - state becomes CLEAR, clr_ptr=0
  - ready=0, rd_data=0, wr_drop=0
  - memory contents are not touched on this edge
- CLEAR, at each edge with reset=0:
  - mem[clr_ptr] <= 0
  - if clr_ptr == DEPTH-1: state becomes RUN and ready becomes 1; otherwise clr_ptr increments
- CLEAR, other behaviour:
  - rd_data is held at 0
  - wr_en=1 is discarded and wr_drop=1 on the next cycle; otherwise wr_drop=0
- RUN, write: if wr_en=1, mem[wr_addr] <= wr_data. Exception: when ZERO_REG=1 and wr_addr=0, the write is ignored silently and wr_drop stays 0.
- RUN, read, for each port i, rd_data[i] <= the first matching value below:
  - 0, if ZERO_REG=1 and rd_addr[i]=0
  - wr_data, if BYPASS=1, wr_en=1 and wr_addr=rd_addr[i]
  - mem[rd_addr[i]] otherwise; this is the pre-write contents
- Multiple read ports may address the same entry; each port resolves independently and identically.
- With BYPASS=0, a read of the register being written in the same cycle returns the old value. The new value is visible from the next edge.

## Timing
- Read latency is 1 cycle: rd_data valid after the edge that samples rd_addr. There is no combinational path from inputs to outputs.
- Write latency is 1 edge into the array. With BYPASS=1 the write is visible on the same edge through rd_data.
- Clear sweep length: ready rises after exactly DEPTH edges with reset=0 following the last reset=1 edge (32 edges at default parameters).
- The edge that sets ready=1 still belongs to CLEAR:
  - a write presented on that edge is dropped
  - rd_data stays 0 on that edge
- Reset asserted mid-sweep restarts the sweep from clr_ptr=0. The full DEPTH edges are required again.
- wr_drop is registered: it asserts the cycle after the dropped write and lasts exactly 1 cycle per dropped write.
- ready remains 1 until the next reset.

## Test plan
- Reset for 2 cycles, then release -> ready=0 for 31 edges and ready=1 after the 32nd; every read after ready returns 0 on all ports.
- Write 0xDEADBEEF to reg 8 while reading reg 8 on port 0 and reg 9 on port 1, same cycle -> next cycle port0=0xDEADBEEF (bypass) and port1=0; with BYPASS=0, port0=0 that cycle and 0xDEADBEEF the cycle after.
- Write 0x12345678 to reg 0 with ZERO_REG=1, then read reg 0 on both ports -> both return 0, wr_drop=0.
- wr_en=1 to reg 5 on the 10th sweep edge -> wr_drop=1 for one cycle; after ready, reading reg 5 returns 0.
- Reset reasserted at sweep edge 20 for 1 cycle -> ready stays low until 32 further edges with reset=0 have elapsed.
- NUM_READ=4, DATA_WIDTH=16, ADDR_WIDTH=3: write 0xA5A5 to reg 7, then all four ports read reg 7 -> all return 0xA5A5; ready after 8 sweep edges.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: NUM_READ registered read ports, one write port,
// optional write-to-read bypass and hardwired zero register, hardware clear sweep.
module regfile_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           ready,
  output logic                           wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                          r_state;
  state_t                          w_next_state;
  logic [ADDR_WIDTH-1:0]           r_clr_ptr;
  logic [ADDR_WIDTH-1:0]           w_next_ptr;
  logic                            w_sweep_last;
  logic                            w_wr_ok;
  logic [DATA_WIDTH-1:0]           r_mem [DEPTH];
  logic [NUM_READ*DATA_WIDTH-1:0]  w_rd_next;
  logic [NUM_READ*DATA_WIDTH-1:0]  r_rd_data;
  logic                            r_ready;
  logic                            r_wr_drop;

  // State register and sweep pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_next_state;
      r_clr_ptr <= w_next_ptr;
    end
  end

  // Next-state logic: walk the pointer through every entry, then run
  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_clr_ptr;
    w_sweep_last = 1'b0;
    case (r_state)
      CLEAR: begin
        if (r_clr_ptr == LAST_PTR) begin
          w_next_state = RUN;
          w_sweep_last = 1'b1;
        end else begin
          w_next_ptr = r_clr_ptr + ADDR_WIDTH'(1);
        end
      end
      RUN: begin
        w_next_state = RUN;
      end
      default: begin
        w_next_state = CLEAR;
      end
    endcase
  end

  // Writes to entry 0 are silently ignored when it is hardwired to zero
  assign w_wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // Storage: the sweep owns the array until it finishes; reset leaves it untouched
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == CLEAR) begin
        r_mem[r_clr_ptr] <= '0;
      end else if (w_wr_ok) begin
        r_mem[wr_addr] <= wr_data;
      end
    end
  end

  // Per-port read resolution: zero register, then bypass, then pre-write contents
  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    assign w_addr = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_rd_next[g*DATA_WIDTH +: DATA_WIDTH] =
        ((ZERO_REG != 0) && (w_addr == '0))                ? '0      :
        ((BYPASS != 0) && wr_en && (wr_addr == w_addr))    ? wr_data :
                                                             r_mem[w_addr];
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
      r_ready   <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= (r_state == CLEAR) && wr_en;
      r_rd_data <= (r_state == RUN) ? w_rd_next : '0;
      if (w_sweep_last) begin
        r_ready <= 1'b1;
      end
    end
  end

  assign rd_data = r_rd_data;
  assign ready   = r_ready;
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default config with and without bypass,
// plus a 4-port 16-bit 8-entry config.
module tb_regfile_param;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two default-size instances
  logic        reset;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [63:0] rd_data_a, rd_data_b;
  logic        ready_a, ready_b, drop_a, drop_b;

  // Stimulus for the small 4-port instance
  logic        reset_c;
  logic [11:0] rd_addr_c;
  logic        wr_en_c;
  logic [2:0]  wr_addr_c;
  logic [15:0] wr_data_c;
  logic [63:0] rd_data_c;
  logic        ready_c, drop_c;

  int n_vec = 0;
  int n_err = 0;

  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready_a), .wr_drop(drop_a));

  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready_b), .wr_drop(drop_b));

  regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .reset(reset_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .wr_en(wr_en_c),
    .wr_addr(wr_addr_c), .wr_data(wr_data_c), .ready(ready_c), .wr_drop(drop_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    reset_c = 1'b1; rd_addr_c = '0; wr_en_c = 1'b0; wr_addr_c = '0; wr_data_c = '0;

    // Reset for two cycles
    tick(); tick();
    check("rst_ready_a", 128'(ready_a), 128'(0));
    check("rst_ready_b", 128'(ready_b), 128'(0));
    check("rst_data_a", 128'(rd_data_a), 128'(0));
    check("rst_drop_a", 128'(drop_a), 128'(0));

    // Clear sweep: drop at edge 10 (reg 5) and edge 32 (reg 6, ready edge)
    reset = 1'b0;
    rd_addr = {5'd6, 5'd5};
    for (int k = 1; k <= 32; k++) begin
      wr_en   = (k == 10) || (k == 32);
      wr_addr = (k == 10) ? 5'd5 : 5'd6;
      wr_data = 32'h5555_AAAA;
      tick();
      check($sformatf("sweep_ready_a_%0d", k), 128'(ready_a), 128'(k == 32));
      check($sformatf("sweep_ready_b_%0d", k), 128'(ready_b), 128'(k == 32));
      if (k == 10 || k == 11 || k == 32) begin
        check($sformatf("sweep_drop_a_%0d", k), 128'(drop_a), 128'(k != 11));
        check($sformatf("sweep_drop_b_%0d", k), 128'(drop_b), 128'(k != 11));
      end
      if (k == 32) check("ready_edge_data_a", 128'(rd_data_a), 128'(0));
    end

    // Dropped writes never landed; whole array reads zero
    wr_en = 1'b0;
    tick();
    check("post_drop_a", 128'(drop_a), 128'(0));
    check("rd56_a", 128'(rd_data_a), 128'(0));
    check("rd56_b", 128'(rd_data_b), 128'(0));
    rd_addr = {5'd1, 5'd31};
    tick();
    check("rd31_1_a", 128'(rd_data_a), 128'(0));

    // Same-cycle write to reg 8 while reading 8 and 9
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEAD_BEEF;
    rd_addr = {5'd9, 5'd8};
    tick();
    check("byp_a", 128'(rd_data_a), 128'({32'h0, 32'hDEAD_BEEF}));
    check("nobyp_b", 128'(rd_data_b), 128'({32'h0, 32'h0}));
    wr_en = 1'b0;
    tick();
    check("after_wr_a", 128'(rd_data_a), 128'({32'h0, 32'hDEAD_BEEF}));
    check("after_wr_b", 128'(rd_data_b), 128'({32'h0, 32'hDEAD_BEEF}));

    // Write to hardwired zero register
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
    rd_addr = {5'd0, 5'd0};
    tick();
    check("zero_wr_a", 128'(rd_data_a), 128'(0));
    check("zero_wr_drop_a", 128'(drop_a), 128'(0));
    wr_en = 1'b0;
    tick();
    check("zero_rd_a", 128'(rd_data_a), 128'(0));
    check("zero_rd_b", 128'(rd_data_b), 128'(0));
    check("zero_drop_a", 128'(drop_a), 128'(0));

    // Both ports on the register being written
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hCAFE_F00D;
    rd_addr = {5'd31, 5'd31};
    tick();
    check("dual_byp_a", 128'(rd_data_a), 128'({32'hCAFE_F00D, 32'hCAFE_F00D}));
    check("dual_nobyp_b", 128'(rd_data_b), 128'(0));
    wr_en = 1'b0;
    tick();
    check("dual_rd_b", 128'(rd_data_b), 128'({32'hCAFE_F00D, 32'hCAFE_F00D}));

    // Reset, then reassert at sweep edge 20: sweep restarts from scratch
    reset = 1'b1;
    tick();
    check("rst2_data_a", 128'(rd_data_a), 128'(0));
    check("rst2_ready_a", 128'(ready_a), 128'(0));
    reset = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 19) check("mid_ready_a", 128'(ready_a), 128'(0));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k >= 30) begin
        check($sformatf("resweep_ready_a_%0d", k), 128'(ready_a), 128'(k == 32));
        check($sformatf("resweep_ready_b_%0d", k), 128'(ready_b), 128'(k == 32));
      end
    end
    tick();
    check("swept31_a", 128'(rd_data_a), 128'(0));
    check("swept31_b", 128'(rd_data_b), 128'(0));

    // Small 4-port configuration
    tick();
    reset_c = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("c_ready_%0d", k), 128'(ready_c), 128'(k == 8));
    end
    wr_en_c = 1'b1; wr_addr_c = 3'd7; wr_data_c = 16'hA5A5;
    rd_addr_c = '0;
    tick();
    check("c_wr7", 128'(rd_data_c), 128'(0));
    wr_en_c = 1'b0;
    rd_addr_c = {3'd7, 3'd7, 3'd7, 3'd7};
    tick();
    check("c_rd7x4", 128'(rd_data_c), 128'({4{16'hA5A5}}));
    wr_en_c = 1'b1; wr_addr_c = 3'd3; wr_data_c = 16'h1234;
    rd_addr_c = {3'd1, 3'd0, 3'd2, 3'd7};
    tick();
    check("c_mix_a", 128'(rd_data_c), 128'({16'h0, 16'h0, 16'h0, 16'hA5A5}));
    wr_en_c = 1'b0;
    rd_addr_c = {3'd1, 3'd0, 3'd3, 3'd7};
    tick();
    check("c_mix_b", 128'(rd_data_c), 128'({16'h0, 16'h0, 16'h1234, 16'hA5A5}));
    check("c_drop", 128'(drop_c), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
